// File: rtl/instr_encoder.sv
// RV32 instruction encoder feeding an instruction-memory write port through a small FIFO.
// Optional macro INSTR_ENC_ILLEGAL_CHECK_EN drops illegal-funct3 requests and pulses err.
module instr_encoder #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 10
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [1:0]               req_kind,
    input  logic [2:0]               funct3,
    input  logic                     funct7_b5,
    input  logic [4:0]               rd,
    input  logic [4:0]               rs1,
    input  logic [4:0]               rs2,
    input  logic [11:0]              imm,
    output logic                     wr_en,
    output logic [ADDR_W-1:0]        wr_addr,
    output logic [31:0]              wr_data,
    input  logic                     wr_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     err
);
    localparam int PW = $clog2(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [31:0]   word;
    logic          legal, accept, push, pop;

    always_comb begin
        word = '0;
        case (req_kind)
            2'b00:   word = {1'b0, funct7_b5, 5'b0, rs2, rs1, funct3, rd, 7'b0110011};
            2'b01:   word = {imm, rs1, funct3, rd, 7'b0000011};
            2'b10:   word = {imm[11:5], rs2, rs1, funct3, imm[4:0], 7'b0100011};
            default: word = {imm[11], imm[9:4], rs2, rs1, funct3, imm[3:0], imm[10], 7'b1100011};
        endcase
    end

`ifdef INSTR_ENC_ILLEGAL_CHECK_EN
    always_comb begin
        legal = 1'b1;
        case (req_kind)
            2'b00:   legal = !funct7_b5 || funct3 == 3'b000 || funct3 == 3'b101;
            2'b01:   legal = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
            2'b10:   legal = funct3 inside {3'b000, 3'b001, 3'b010};
            default: legal = funct3 != 3'b010 && funct3 != 3'b011;
        endcase
    end

    // An illegal request still handshakes; it is reported one cycle later instead of queued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err <= 1'b0;
        else        err <= accept && !legal;
    end
`else
    assign legal = 1'b1;
    assign err   = 1'b0;
`endif

    assign req_ready = count != (PW+1)'(DEPTH);
    assign wr_en     = count != '0;
    assign wr_data   = wr_en ? mem[rd_ptr] : '0;
    assign accept    = req_valid && req_ready && !clear;
    assign push      = accept && legal;
    assign pop       = wr_en && wr_ready && !clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            wr_addr <= '0;
        end else if (clear) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            wr_addr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr  <= rd_ptr + 1'b1;
                wr_addr <= wr_addr + ADDR_W'(4);
            end
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
        end
    end

    // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= word;
    end
endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 The module SHALL have parameter DEPTH, default 4, meaning the number of encoded-word FIFO entries (power of two, at least 2).
REQ-002 The module SHALL have parameter ADDR_W, default 10, meaning the instruction-memory byte-address width.
REQ-003 The module SHALL have port clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 The module SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 The module SHALL have port clear  input  1  synchronous flush of the FIFO and the address counter.
REQ-006 The module SHALL have ports req_valid input 1 and req_ready output 1, forming the request handshake.
REQ-007 The module SHALL have port req_kind  input  2  instruction kind: 00 R-type, 01 load, 10 store, 11 beq-class branch.
REQ-008 The module SHALL have ports funct3 input 3, funct7_b5 input 1 (R-type SUB/SRA bit), and rd, rs1, rs2 input 5 each.
REQ-009 The module SHALL have port imm  input  12  I/S immediate[11:0]; for branches, byte offset[12:1].
REQ-010 The module SHALL have ports wr_en output 1, wr_addr output ADDR_W, wr_data output 32, and wr_ready input 1, forming the instruction-memory write port.
REQ-011 The module SHALL have port count  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-012 The module SHALL have port err  output  1  one-cycle illegal-request pulse (only when checking is compiled in).

Function
REQ-013 Encoding SHALL be as follows.
  - R-type: {1'b0, funct7_b5, 5'b0, rs2, rs1, funct3, rd, 7'b0110011}.
  - Load: {imm, rs1, funct3, rd, 7'b0000011}.
  - Store: {imm[11:5], rs2, rs1, funct3, imm[4:0], 7'b0100011}.
  - Branch: {imm[11], imm[9:4], rs2, rs1, funct3, imm[3:0], imm[10], 7'b1100011}.
REQ-014 Unused fields for a kind SHALL be ignored.
REQ-015 req_ready SHALL equal !full, where full means count==DEPTH; a push SHALL occur when req_valid && req_ready.
REQ-016 A word pushed at edge N SHALL be visible on wr_data with wr_en=1 from cycle N+1 if the FIFO was empty (one-cycle latency).
REQ-017 wr_en SHALL equal !empty; wr_data SHALL be the FIFO head, registered and stable while wr_en && !wr_ready.
REQ-018 A pop SHALL occur when wr_en && wr_ready; words SHALL leave in push order.
REQ-019 Simultaneous push and pop SHALL leave count unchanged; when full, no push SHALL occur even if a pop occurs in the same cycle.
REQ-020 wr_addr SHALL start at 0 and increment by 4 after each pop, wrapping modulo 2^ADDR_W.
REQ-021 clear SHALL empty the FIFO and set wr_addr to 0; clear SHALL override any push or pop in the same cycle, and the request offered in that cycle SHALL be dropped.
REQ-022 The FIFO read and write pointers SHALL wrap modulo DEPTH.

Reset
REQ-023 rst_n low SHALL immediately force count=0, wr_en=0, wr_addr=0, err=0, and req_ready=1; wr_data SHALL be 0.
REQ-024 Reset mid-transfer SHALL discard all queued words, with no partial write completing afterwards.
REQ-025 The first accepted request SHALL be possible on the first rising edge after rst_n deasserts.

Configuration
REQ-026 With macro INSTR_ENC_ILLEGAL_CHECK_EN defined, each accepted request SHALL be validated against the following legal funct3 sets.
  - Load: {000,001,010,100,101}.
  - Store: {000,001,010}.
  - Branch: {000,001,100,101,110,111}.
  - R-type: funct7_b5=1 only with funct3 000 or 101.
REQ-027 With INSTR_ENC_ILLEGAL_CHECK_EN defined, an illegal request SHALL still complete its handshake, SHALL NOT be enqueued, and SHALL pulse err for exactly the following cycle.
REQ-028 With INSTR_ENC_ILLEGAL_CHECK_EN undefined, every accepted request SHALL be encoded verbatim and err SHALL be tied to 0.

Verification
REQ-029 The bench SHALL check R-type encoding: kind 00, f3 000, b5 0, rd 3, rs1 1, rs2 2 -> wr_data 0x002081B3, wr_addr 0; then b5 1, rd 5, rs1 6, rs2 7 -> 0x407302B3 at wr_addr 4.
REQ-030 The bench SHALL check load/store/branch encoding.
  - kind 01, f3 010, rd 5, rs1 2, imm 8 -> 0x00812283.
  - kind 10, f3 010, rs2 5, rs1 2, imm 12 -> 0x00512623.
  - kind 11, f3 000, rs1 1, rs2 2, imm 4 -> 0x00208463.
REQ-031 The bench SHALL check backpressure: with wr_ready=0, after 4 pushes req_ready=0 and count=4; then wr_ready=1 and req_valid=1 for one cycle -> one pop, no push, count=3.
REQ-032 The bench SHALL check address wrap: with ADDR_W=4 and 5 transfers -> wr_addr sequence 0,4,8,12,0.
REQ-033 The bench SHALL check clear and reset: with 3 words queued, asserting clear together with req_valid -> count=0, wr_en=0, wr_addr=0 next cycle; asserting rst_n low asynchronously mid-stall -> outputs reset before the next clock edge.
REQ-034 The bench SHALL check illegal requests: with INSTR_ENC_ILLEGAL_CHECK_EN defined, kind 10 with f3 111 -> req_ready=1, err=1 for one cycle, count unchanged; with the macro undefined -> word 0x00007023 is enqueued for all other fields 0.
